// File: rtl/mastermind_code_sequencer.sv
// Draws a Mastermind secret code from an external 10-bit XNOR LFSR, keeping the LFSR stepping
// every cycle so player timing supplies entropy, and clearing the LFSR out of its all-ones lock-up.
module mastermind_code_sequencer #(
  parameter int NUM_PEGS     = 4,
  parameter int NUM_COLORS   = 6,
  parameter int STRIDE       = 3,
  parameter int ALLOW_REPEAT = 1,
  parameter int MAX_ATTEMPTS = 16
) (
  input  logic                    clk,
  input  logic                    Reset,
  input  logic                    start,
  input  logic [9:0]              lfsr_q,
  output logic                    lfsr_step,
  output logic                    lfsr_clear,
  output logic                    busy,
  output logic                    code_valid,
  output logic                    error,
  output logic [3*NUM_PEGS-1:0]   code
);

  // state | meaning
  // IDLE  | LFSR free-running; code, code_valid and error held from the last draw
  // DRAW  | one candidate per STRIDE LFSR steps until the code is full or attempts run out
  typedef enum logic {IDLE = 1'b0, DRAW = 1'b1} state_t;

  localparam int AW = $clog2(MAX_ATTEMPTS + 1);
  localparam int IW = $clog2(NUM_PEGS + 1);
  localparam int SW = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  state_t        state;
  logic [AW-1:0] attempts;
  logic [IW-1:0] idx;
  logic [SW-1:0] stride;

  logic       lock;
  logic [2:0] cand;
  logic       dup;
  logic       legal;
  logic       accept;
  logic       eval;

  assign lock       = (lfsr_q == 10'h3FF);
  assign lfsr_clear = Reset & lock;
  assign lfsr_step  = Reset & ~lock;
  assign busy       = (state == DRAW);

  assign cand = lfsr_q[2:0];

  // Only pegs already accepted in this draw count as duplicates.
  always_comb begin
    dup = 1'b0;
    for (int p = 0; p < NUM_PEGS; p++) begin
      if ((IW'(p) < idx) && (code[3*p +: 3] == cand)) dup = 1'b1;
    end
  end

  assign legal  = (int'(cand) < NUM_COLORS);
  assign accept = legal && ((ALLOW_REPEAT != 0) || !dup);
  assign eval   = (state == DRAW) && lfsr_step && (stride == SW'(STRIDE - 1));

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state      <= IDLE;
      code_valid <= 1'b0;
      error      <= 1'b0;
      code       <= '0;
      attempts   <= '0;
      idx        <= '0;
      stride     <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        state      <= DRAW;
        code_valid <= 1'b0;
        error      <= 1'b0;
        code       <= '0;
        attempts   <= '0;
        idx        <= '0;
        stride     <= '0;
      end
    end else if (lfsr_step) begin
      if (eval) begin
        stride   <= '0;
        attempts <= attempts + 1'b1;
        if (accept) begin
          code[3*idx +: 3] <= cand;
          idx              <= idx + 1'b1;
        end
        // A final accept on the last allowed attempt still completes the code.
        if (accept && (idx == IW'(NUM_PEGS - 1))) begin
          state      <= IDLE;
          code_valid <= 1'b1;
        end else if (attempts == AW'(MAX_ATTEMPTS - 1)) begin
          state <= IDLE;
          error <= 1'b1;
          code  <= '0;
        end
      end else begin
        stride <= stride + 1'b1;
      end
    end
  end

endmodule
